mul_share_arb: RTL and testbench
================================

Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one multi-cycle shift-add multiplier between several requesters.
- Typical requesters are the cube and sqrt units behind the top-level function block.
- Each requester presents operands with a level request and receives a one-cycle ack together with the product.
- Only one multiply is in flight at a time.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- W, 8, operand width in bits; the product is 2*W bits.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  synchronous active-high reset.
- req_i  input  N_REQ  level request, one bit per requester.
- a_bi  input  N_REQ*W  multiplicand; requester k occupies bits [k*W +: W].
- b_bi  input  N_REQ*W  multiplier; same packing as a_bi.
- grant_o  output  N_REQ  one-hot; identifies the requester that owns the unit.
- ack_o  output  N_REQ  one-cycle pulse to the granted requester; y_bo is valid in that cycle.
- y_bo  output  2*W  registered product; holds its value until the next ack.
- busy_o  output  1  high while an operation is in progress.

Behaviour:
- Reset, applied at any time including mid-operation:
  - state=IDLE, grant_o=0, ack_o=0, y_bo=0, busy_o=0, round-robin pointer ptr=0.
  - Any partial product is discarded.
- States:
  - IDLE: busy_o=0, grant_o=0.
    - If any req_i bit is set, the grantee g is the first set bit searching upward from ptr, wrapping modulo N_REQ.
    - On that edge: latch a[g] and b[g] into internal registers, set grant_o=onehot(g), clear the accumulator, cnt=0, go to MUL.
  - MUL: busy_o=1.
    - Each edge processes one multiplier bit, LSB first: if b_reg[0], acc += a_reg << cnt; then b_reg >>= 1, cnt++.
    - After exactly W MUL edges: y_bo <= acc (including the final bit), ack_o <= onehot(g), go to DONE.
  - DONE: busy_o=1, ack_o[g]=1, grant_o held.
    - Next edge: ack_o=0, grant_o=0, ptr <= (g+1) mod N_REQ, go to IDLE.
- Latency:
  - req sampled at edge E0 -> ack high during the cycle after edge E0+W.
  - Earliest next grant is at edge E0+W+2.
- Handshake:
  - Requester holds req and operands until it sees ack.
  - Requester must drop req at or before the edge that ends the ack cycle; otherwise it re-enters arbitration as a new request.
  - Operands are latched at grant, so later changes to a_bi/b_bi have no effect on the current operation.
- Boundary conditions:
  - req withdrawn during MUL/DONE: the operation still completes and ack still pulses.
  - New requests arriving during MUL/DONE: wait in IDLE arbitration.
  - Simultaneous requests: the pointer order decides.
  - Starvation-free: a held request is served within N_REQ operations.
- Arithmetic:
  - Unsigned, exact; (2^W-1)^2 fits in 2*W bits.
  - The accumulator is 2*W bits; there is no overflow path.

Optional Feature:
- Macro: MUL_ZERO_SKIP_EN.
- Defined: in IDLE, if the selected a or b is 0, go directly to DONE with y_bo=0. Ack then arrives in the cycle after the grant edge (latency 1), and ptr still advances.
- Undefined: zero operands take the full W MUL cycles and produce y_bo=0.

Decomposition:
- Shared package mul_share_pkg holds:
  - state encoding localparams (IDLE, MUL, DONE);
  - default W;
  - a function rr_pick(req, ptr) returning the grantee index.
- One natural sub-module: mul_shift_add.
  - Ports: clk_i, rst_i, start_i, a_bi, b_bi, done_o, y_bo.
  - It holds the acc, b_reg and cnt datapath.
  - The arbiter keeps the FSM, pointer, grant and ack logic.

Test Plan:
1. W=8, N_REQ=2; req0 only, a=13, b=11 -> grant_o=01; ack_o=01 for exactly 1 cycle, W+1 cycles after the sampling edge; y_bo=143; busy_o=0 afterwards.
2. After reset, req0 (a=255, b=255) and req1 (a=3, b=4) asserted together -> req0 served first with y_bo=65025; then req1 with y_bo=12.
3. Both requests held continuously for 4 operations, each dropped and re-raised around its own ack -> grant order 0,1,0,1; no requester granted twice in a row while the other waits.
4. rst_i pulsed on the 4th MUL cycle of a req0 operation (a=7, b=9) -> no ack; y_bo=0, busy_o=0, grant_o=0 next cycle. Then req1 only (a=2, b=5) -> served with y_bo=10.
5. req0 with a=0, b=200 -> y_bo=0. With MUL_ZERO_SKIP_EN, ack comes 1 cycle after grant; without it, ack comes after W+1 cycles.
6. req0 dropped and a_bi changed to 99 two cycles into MUL (original a=6, b=6) -> ack_o=01 still pulses with y_bo=36.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// State encoding, default operand width and the round-robin pick function.
package mul_share_pkg;

    localparam int W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_MUL  = ST_MUL,
        S_DONE = ST_DONE
    } state_e;

    // First set bit of req searching upward from ptr, wrapping modulo n (n <= 8).
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                           input int unsigned n);
        logic [2:0] pick;
        logic [3:0] idx;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = {1'b0, ptr} + 4'(i);
            if (idx >= 4'(n)) begin
                idx = idx - 4'(n);
            end
            if (!found && (i < n) && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mul_share_arb_mul_shift_add.sv
// Sequential shift-add multiplier: one multiplier bit per clock, LSB first.
// done_o marks the last bit cycle; y_bo is the product including that bit.
module mul_shift_add
    import mul_share_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [W-1:0]   a_bi,
    input  logic [W-1:0]   b_bi,
    output logic           done_o,
    output logic [2*W-1:0] y_bo
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_d;
    logic [2*W-1:0] a_q;
    logic [W-1:0]   b_q;
    logic [CW-1:0]  cnt_q;
    logic           run_q;

    // a_q is shifted each cycle, which equals adding a << cnt.
    assign acc_d  = acc_q + (b_q[0] ? a_q : '0);
    assign done_o = run_q && (cnt_q == CW'(W - 1));
    assign y_bo   = acc_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= '0;
            a_q   <= {{W{1'b0}}, a_bi};
            b_q   <= b_bi;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
            cnt_q <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter sharing one shift-add multiplier among N_REQ requesters.
// Optional MUL_ZERO_SKIP_EN: a zero operand skips MUL and acks one cycle after grant.
//   state | meaning
//   IDLE  | arbitrate among req_i, latch operands of the winner
//   MUL   | multiplier stepping, one bit per clock
//   DONE  | ack pulse to grantee, pointer advances on exit
module mul_share_arb
    import mul_share_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*W-1:0] a_bi,
    input  logic [N_REQ*W-1:0] b_bi,
    output logic [N_REQ-1:0]   grant_o,
    output logic [N_REQ-1:0]   ack_o,
    output logic [2*W-1:0]     y_bo,
    output logic               busy_o
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      g_q, g_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [2*W-1:0]     y_q, y_d;

    logic [PW-1:0]      pick;
    logic [N_REQ-1:0]   pick_oh;
    logic [W-1:0]       a_sel;
    logic [W-1:0]       b_sel;
    logic               mul_start;
    logic               mul_done;
    logic [2*W-1:0]     mul_y;

    assign pick    = PW'(rr_pick(8'(req_i), 3'(ptr_q), N_REQ));
    assign pick_oh = N_REQ'(1) << pick;
    assign a_sel   = a_bi[int'(pick) * W +: W];
    assign b_sel   = b_bi[int'(pick) * W +: W];

    mul_shift_add #(.W(W)) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (mul_start),
        .a_bi    (a_sel),
        .b_bi    (b_sel),
        .done_o  (mul_done),
        .y_bo    (mul_y)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        g_d       = g_q;
        grant_d   = grant_q;
        ack_d     = '0;
        y_d       = y_q;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    g_d     = pick;
                    grant_d = pick_oh;
`ifdef MUL_ZERO_SKIP_EN
                    if ((a_sel == '0) || (b_sel == '0)) begin
                        y_d     = '0;
                        ack_d   = pick_oh;
                        state_d = S_DONE;
                    end else begin
                        mul_start = 1'b1;
                        state_d   = S_MUL;
                    end
`else
                    mul_start = 1'b1;
                    state_d   = S_MUL;
`endif
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    y_d     = mul_y;
                    ack_d   = grant_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                ptr_d   = (g_q == PW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            y_q     <= y_d;
        end
    end

    assign grant_o = grant_q;
    assign ack_o   = ack_q;
    assign y_bo    = y_q;
    assign busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_share_arb.sv
// Scoreboard bench for mul_share_arb: stimulus pushes expected (owner, product),
// a negedge monitor pops and compares on every ack.
module tb_mul_share_arb;

    localparam int N_REQ = 2;
    localparam int W     = 8;
`ifdef MUL_ZERO_SKIP_EN
    localparam int ZLAT = 0;
`else
    localparam int ZLAT = W;
`endif

    logic               clk;
    logic               rst;
    logic [N_REQ-1:0]   req_v;
    logic [N_REQ*W-1:0] a_v;
    logic [N_REQ*W-1:0] b_v;
    logic [N_REQ-1:0]   grant_o;
    logic [N_REQ-1:0]   ack_o;
    logic [2*W-1:0]     y_bo;
    logic               busy_o;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int             idx;
        logic [2*W-1:0] y;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    mul_share_arb #(.N_REQ(N_REQ), .W(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .req_i   (req_v),
        .a_bi    (a_v),
        .b_bi    (b_v),
        .grant_o (grant_o),
        .ack_o   (ack_o),
        .y_bo    (y_bo),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N_REQ-1:0] onehot(input int k);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input int k, input logic [2*W-1:0] y);
        exp_t e;
        e.idx = k;
        e.y   = y;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (ack_o != '0)) begin
            if (sbq.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_ack: got ack=%b y=%0d, required no ack (t=%0t)",
                         ack_o, y_bo, $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("ack_owner", 32'(ack_o), 32'(onehot(mon_e.idx)));
                chk("product", 32'(y_bo), 32'(mon_e.y));
            end
        end
    end

    task automatic wait_ack_drop();
        int n;
        n = 0;
        while (ack_o == '0 && n < 40) begin
            tick();
            n++;
        end
        chk("ack_seen", 32'(n < 40), 32'd1);
        req_v = req_v & ~ack_o;
    endtask

    // Single-requester operation; mess > 0 drops req and corrupts a after that many MUL ticks.
    task automatic serve(input int k, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] y, input int lat, input int mess);
        int n;
        sb_push(k, y);
        a_v[k*W +: W] = av;
        b_v[k*W +: W] = bv;
        req_v[k] = 1'b1;
        tick();
        chk("grant", 32'(grant_o), 32'(onehot(k)));
        chk("busy_run", 32'(busy_o), 32'd1);
        n = 0;
        while (ack_o == '0 && n < 40) begin
            if (mess != 0 && n == mess) begin
                req_v[k] = 1'b0;
                a_v[k*W +: W] = 8'd99;
            end
            tick();
            n++;
        end
        chk("ack_latency", 32'(n), 32'(lat));
        req_v[k] = 1'b0;
        tick();
        chk("ack_width", 32'(ack_o), 32'd0);
        chk("busy_idle", 32'(busy_o), 32'd0);
        chk("grant_idle", 32'(grant_o), 32'd0);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req_v = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        req_v = '0;
        a_v   = '0;
        b_v   = '0;
        do_reset();
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_y", 32'(y_bo), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);

        // 1: single request, full latency
        serve(0, 8'd13, 8'd11, 16'd143, W, 0);
        chk("y_hold", 32'(y_bo), 32'd143);

        // 2: simultaneous requests after reset, pointer at 0
        do_reset();
        a_v = {8'd3, 8'd255};
        b_v = {8'd4, 8'd255};
        sb_push(0, 16'd65025);
        sb_push(1, 16'd12);
        req_v = 2'b11;
        tick();
        chk("sim_grant0", 32'(grant_o), 32'd1);
        wait_ack_drop();
        tick();
        tick();
        chk("sim_grant1", 32'(grant_o), 32'd2);
        wait_ack_drop();
        tick();

        // 3: both held, each re-raised after its own ack -> alternate
        a_v   = {8'd9, 8'd5};
        b_v   = {8'd10, 8'd6};
        req_v = 2'b11;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = i % 2;
            sb_push(k, (k == 1) ? 16'd90 : 16'd30);
            tick();
            chk("rr_grant", 32'(grant_o), 32'(onehot(k)));
            wait_ack_drop();
            if (i == 3) req_v = '0;
            tick();
            if (i < 3) req_v[k] = 1'b1;
        end

        // 4: reset in the 4th MUL cycle, no ack expected
        a_v   = {8'd2, 8'd7};
        b_v   = {8'd5, 8'd9};
        req_v = 2'b01;
        tick();
        repeat (3) tick();
        rst   = 1'b1;
        req_v = '0;
        tick();
        rst = 1'b0;
        chk("mid_rst_y", 32'(y_bo), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_grant", 32'(grant_o), 32'd0);
        chk("mid_rst_ack", 32'(ack_o), 32'd0);
        repeat (12) tick();
        serve(1, 8'd2, 8'd5, 16'd10, W, 0);

        // 5: zero multiplicand
        serve(0, 8'd0, 8'd200, 16'd0, ZLAT, 0);

        // 6: req dropped and operand changed during MUL
        serve(0, 8'd6, 8'd6, 16'd36, W, 2);

        repeat (3) tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
